// File: rtl/led_pwm_ctrl.sv
// LED brightness/fade driver: free-running PWM with period-boundary sampling of
// the LED pattern and a per-period ramp of the current duty toward a target.
module led_pwm_ctrl #(
    parameter int PWM_BITS   = 8,
    parameter int FADE_STEP  = 1,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [7:0]          led_in,
    input  logic [PWM_BITS-1:0] duty_target,
    input  logic                duty_we,
    output logic [7:0]          led,
    output logic                period_tick,
    output logic                fading,
    output logic [1:0]          fade_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } fade_state_t;

    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
    localparam logic [PWM_BITS:0]   STEP    = (PWM_BITS + 1)'(FADE_STEP);
    localparam logic [7:0]          LED_OFF = {8{ACTIVE_LOW}};

    logic [PWM_BITS-1:0] cnt, cnt_d;
    logic [PWM_BITS-1:0] cur, cur_d;
    logic [PWM_BITS-1:0] tgt, tgt_d;
    logic [7:0]          pat, pat_d;
    logic [7:0]          led_d;
    logic [PWM_BITS:0]   up_sum;
    logic [PWM_BITS:0]   down_gap;
    logic                boundary;
    fade_state_t         state, state_d;

    // state always mirrors the cur/tgt comparison, so the step taken at a
    // boundary uses the target as it stood before any same-cycle write.
    always_comb begin
        boundary = (cnt == CNT_MAX);
        cnt_d    = cnt + 1'b1;
        tgt_d    = duty_we ? duty_target : tgt;
        pat_d    = boundary ? led_in : pat;
        up_sum   = {1'b0, cur} + STEP;
        down_gap = {1'b0, cur - tgt};
        cur_d    = cur;
        if (boundary) begin
            case (state)
                UP:      cur_d = (up_sum > {1'b0, tgt}) ? tgt : up_sum[PWM_BITS-1:0];
                DOWN:    cur_d = (down_gap <= STEP) ? tgt : cur - STEP[PWM_BITS-1:0];
                default: cur_d = cur;
            endcase
        end
        state_d = IDLE;
        if (cur_d < tgt_d) begin
            state_d = UP;
        end else if (cur_d > tgt_d) begin
            state_d = DOWN;
        end
        led_d = (pat & {8{cnt < cur}}) ^ LED_OFF;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt         <= '0;
            cur         <= '0;
            tgt         <= '0;
            pat         <= '0;
            state       <= IDLE;
            led         <= LED_OFF;
            period_tick <= 1'b0;
            fading      <= 1'b0;
        end else begin
            cnt         <= cnt_d;
            cur         <= cur_d;
            tgt         <= tgt_d;
            pat         <= pat_d;
            state       <= state_d;
            led         <= led_d;
            period_tick <= (cnt_d == CNT_MAX);
            fading      <= (cur_d != tgt_d);
        end
    end

    assign fade_state = state;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Bench for led_pwm_ctrl (PWM_BITS=4, FADE_STEP=3, active-low): a cycle model
// feeds an expected queue; directed sections walk the ramp and pattern cases.
module tb_led_pwm_ctrl;

    localparam int PW   = 4;
    localparam int STEP = 3;
    localparam bit AL   = 1'b1;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [7:0]   led_in;
    logic [PW-1:0] duty_target;
    logic         duty_we;
    logic [7:0]   led;
    logic         period_tick;
    logic         fading;
    logic [1:0]   fade_state;

    led_pwm_ctrl #(.PWM_BITS(PW), .FADE_STEP(STEP), .ACTIVE_LOW(AL)) dut (
        .clk(clk), .reset_n(reset_n), .led_in(led_in), .duty_target(duty_target),
        .duty_we(duty_we), .led(led), .period_tick(period_tick), .fading(fading),
        .fade_state(fade_state)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [19:0] exp_q[$];
    string       phase = "reset";

    int          m_cnt = 0;
    int          m_cur = 0;
    int          m_tgt = 0;
    logic [7:0]  m_pat = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour at one rising edge; pushes the expected post-edge view.
    task automatic model_edge();
        logic [7:0]  on;
        logic [7:0]  e_led;
        logic [19:0] w;
        int          n_cur;
        int          st;
        if (!reset_n) begin
            m_cnt = 0; m_cur = 0; m_tgt = 0; m_pat = 8'h00;
            w = {8'hFF, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0};
        end else begin
            on    = (m_cnt < m_cur) ? m_pat : 8'h00;
            e_led = AL ? ~on : on;
            n_cur = m_cur;
            if (m_cnt == (1 << PW) - 1) begin
                m_pat = led_in;
                if (m_cur < m_tgt)
                    n_cur = (m_cur + STEP > m_tgt) ? m_tgt : m_cur + STEP;
                else if (m_cur > m_tgt)
                    n_cur = (m_cur - STEP < m_tgt) ? m_tgt : m_cur - STEP;
            end
            if (duty_we) m_tgt = int'(duty_target);
            m_cur = n_cur;
            m_cnt = (m_cnt + 1) % (1 << PW);
            st = (m_cur < m_tgt) ? 1 : (m_cur > m_tgt) ? 2 : 0;
            w = {e_led, 1'(m_cnt == (1 << PW) - 1), 1'(m_cur != m_tgt), 2'(st), 4'(m_cur), 4'(m_cnt)};
        end
        exp_q.push_back(w);
    endtask

    task automatic cycle();
        logic [19:0] got;
        logic [19:0] exp;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        got = {led, period_tick, fading, fade_state, dut.cur, dut.cnt};
        exp = exp_q.pop_front();
        check({"sb_", phase}, 32'(got), 32'(exp));
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!period_tick && n < 40);
        check({tag, "_tick"}, 32'(period_tick), 32'd1);
    endtask

    task automatic write_duty(input logic [PW-1:0] v);
        duty_target = v;
        duty_we = 1'b1;
        cycle();
        duty_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int act;
        int other;
        int glitch;
        int up_seq[4];
        int rise_seq[3];
        up_seq   = '{3, 6, 9, 10};
        rise_seq = '{7, 10, 12};

        reset_n = 1'b0; led_in = 8'h00; duty_target = '0; duty_we = 1'b0;
        repeat (3) cycle();
        check("reset_led", 32'(led), 32'hFF);
        check("reset_cnt", 32'(dut.cnt), 32'd0);
        check("reset_fading", 32'(fading), 32'd0);
        check("reset_tick", 32'(period_tick), 32'd0);

        phase = "release";
        reset_n = 1'b1;
        n = 1;
        while (!period_tick && n < 40) begin
            cycle();
            n++;
        end
        check("first_tick_cycle", 32'(n), 32'd16);

        phase = "duty4";
        led_in = 8'h01;
        write_duty(4);
        repeat (48) cycle();
        check("duty4_cur", 32'(dut.cur), 32'd4);
        act = 0; other = 0;
        repeat (16) begin
            cycle();
            if (!led[0]) act++;
            if (led[7:1] != 7'h7F) other++;
        end
        check("duty4_active", 32'(act), 32'd4);
        check("duty4_others", 32'(other), 32'd0);

        phase = "ramp_up";
        write_duty(0);
        repeat (48) cycle();
        check("to_zero_fading", 32'(fading), 32'd0);
        wait_tick("up_align");
        cycle();
        write_duty(10);
        for (int i = 0; i < 4; i++) begin
            wait_tick("up");
            cycle();
            check($sformatf("up_cur%0d", i), 32'(dut.cur), 32'(up_seq[i]));
            if (i == 2) check("up_fading_mid", 32'(fading), 32'd1);
            if (i == 3) check("up_fading_done", 32'(fading), 32'd0);
        end

        phase = "ramp_down";
        write_duty(1);
        wait_tick("down");
        cycle();
        check("down_cur0", 32'(dut.cur), 32'd7);
        wait_tick("down");
        duty_target = 4'd12;
        duty_we = 1'b1;
        cycle();
        duty_we = 1'b0;
        check("down_cur_oldtgt", 32'(dut.cur), 32'd4);
        check("down_tgt_new", 32'(dut.tgt), 32'd12);
        for (int i = 0; i < 3; i++) begin
            wait_tick("rise");
            cycle();
            check($sformatf("rise_cur%0d", i), 32'(dut.cur), 32'(rise_seq[i]));
        end
        check("rise_fading_done", 32'(fading), 32'd0);

        phase = "pattern";
        write_duty(15);
        led_in = 8'h0F;
        wait_tick("pat");
        cycle();
        repeat (6) cycle();
        led_in = 8'hF0;
        glitch = 0;
        n = 0;
        do begin
            cycle();
            n++;
            if (led[7:4] != 4'hF) glitch++;
        end while (!period_tick && n < 20);
        check("pat_tick", 32'(period_tick), 32'd1);
        check("pat_no_glitch", 32'(glitch), 32'd0);
        cycle();
        check("pat_lag", 32'(led), 32'hFF);
        cycle();
        check("pat_new", 32'(led), 32'h0F);

        phase = "reset_mid";
        write_duty(2);
        wait_tick("rst");
        cycle();
        n = 0;
        while (m_cnt != 9 && n < 20) begin
            cycle();
            n++;
        end
        check("rst_at_cnt9", 32'(dut.cnt), 32'd9);
        reset_n = 1'b0;
        cycle();
        check("rst_led", 32'(led), 32'hFF);
        check("rst_cur", 32'(dut.cur), 32'd0);
        check("rst_tgt", 32'(dut.tgt), 32'd0);
        check("rst_fading", 32'(fading), 32'd0);
        check("rst_cnt", 32'(dut.cnt), 32'd0);
        reset_n = 1'b1;

        phase = "random";
        repeat (400) begin
            led_in = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) begin
                duty_target = 4'($urandom_range(0, 15));
                duty_we = 1'b1;
            end else begin
                duty_we = 1'b0;
            end
            cycle();
        end
        duty_we = 1'b0;
        repeat (4) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
